// File: rtl/raytrace_pkg.sv
// raytrace_pkg
// Shared types and helpers for the ray-tracing front end. The dispatcher and
// the pixel collector both import this package so that they agree on the core
// count and its clamping rule.
//   dispatch_state_t : IDLE / ISSUE / DONE states of the pixel dispatcher
//   MAX_CORES        : number of ray-tracing cores in the array
//   CORE_W           : width of a core index
//   clamp_core_last  : maps no_of_extra_cores (0..7) to the last active core
//                      index (0..3), so that values 4..7 mean all four cores
package raytrace_pkg;

  localparam int MAX_CORES = 4;
  localparam int CORE_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } dispatch_state_t;

  // Returns core_num - 1, where core_num = min(extra, 3) + 1.
  function automatic logic [CORE_W-1:0] clamp_core_last(input logic [2:0] extra);
    if (extra > 3'd3) begin
      return 2'd3;
    end
    return extra[CORE_W-1:0];
  endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter
// Raster-order x/y coordinate counter (x fastest). It wraps back to (0,0)
// after the last pixel of the frame, so the owner only needs to pulse clear at
// the start of a frame.
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   clear         : force the coordinates back to (0,0)
//   advance       : step to the next pixel in raster order
//   width_m1      : frame width minus one (last x value)
//   height_m1     : frame height minus one (last y value)
//   x, y          : current coordinates
//   last          : current coordinate is the final pixel of the frame
module raster_counter #(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           clear,
  input  logic           advance,
  input  logic [X_W-1:0] width_m1,
  input  logic [Y_W-1:0] height_m1,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic line_end;
  logic frame_end;

  // Comparing against width-1 (rather than x+1 against width) keeps the
  // largest 2^X_W-wide frame free of overflow in the compare.
  assign line_end  = (x == width_m1);
  assign frame_end = (y == height_m1);
  assign last      = line_end && frame_end;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (line_end) begin
        x <= '0;
        y <= frame_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher
// Hands out pixel jobs in raster order to up to four ray-tracing cores, strictly
// round-robin (pixel n goes to core n mod core_num), so that the downstream
// collector can rebuild the output stream in order. A job sits on the shared
// job_x/job_y bus with exactly one job_valid_k high until that core's
// compute_ready_k accepts it.
// Optional feature macro: PIXEL_DISPATCH_ABORT_EN adds abort / aborted.
// Ports:
//   aclk, aresetn              : clock, synchronous active-low reset
//   start                      : begins a frame (only honoured in IDLE)
//   frame_width, frame_height  : frame size, sampled on an accepted start
//   no_of_extra_cores          : active cores minus one (4..7 clamp to 4 cores)
//   compute_ready_1..4         : core k can take a job
//   abort / aborted            : (macro only) stop the frame / frame was stopped
//   job_x, job_y               : coordinates of the pending job
//   job_valid_1..4             : pending job is addressed to core k
//   busy                       : frame in progress
//   frame_done                 : one-cycle pulse when the frame ends
module pixel_dispatcher
  import raytrace_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           start,
  input  logic [X_W-1:0] frame_width,
  input  logic [Y_W-1:0] frame_height,
  input  logic [2:0]     no_of_extra_cores,
  input  logic           compute_ready_1,
  input  logic           compute_ready_2,
  input  logic           compute_ready_3,
  input  logic           compute_ready_4,
`ifdef PIXEL_DISPATCH_ABORT_EN
  input  logic           abort,
  output logic           aborted,
`endif
  output logic [X_W-1:0] job_x,
  output logic [Y_W-1:0] job_y,
  output logic           job_valid_1,
  output logic           job_valid_2,
  output logic           job_valid_3,
  output logic           job_valid_4,
  output logic           busy,
  output logic           frame_done
);

  dispatch_state_t       state, state_next;
  logic [MAX_CORES-1:0]  valid, valid_next;
  logic [MAX_CORES-1:0]  ready;
  logic [CORE_W-1:0]     core_idx, core_next;
  logic [CORE_W-1:0]     core_last;
  logic [X_W-1:0]        width_m1;
  logic [Y_W-1:0]        height_m1;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  load_cfg;
  logic                  accept;
  logic                  advance;
  logic                  last;
  logic                  frame_empty;
`ifdef PIXEL_DISPATCH_ABORT_EN
  logic                  aborted_reg, aborted_next;
`endif

  function automatic logic [MAX_CORES-1:0] core_onehot(input logic [CORE_W-1:0] idx);
    return {{(MAX_CORES-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign ready       = {compute_ready_4, compute_ready_3, compute_ready_2, compute_ready_1};
  // Only the addressed core's ready matters, since valid is one-hot.
  assign accept      = |(valid & ready);
  assign frame_empty = (frame_width == '0) || (frame_height == '0);

  raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clear     (load_cfg),
    .advance   (advance),
    .width_m1  (width_m1),
    .height_m1 (height_m1),
    .x         (job_x),
    .y         (job_y),
    .last      (last)
  );

  // Next-state and next-output logic. Every output is a flop, so this block
  // computes the value each output takes in the following cycle.
  always_comb begin
    state_next = state;
    valid_next = valid;
    core_next  = core_idx;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    load_cfg   = 1'b0;
    advance    = 1'b0;
`ifdef PIXEL_DISPATCH_ABORT_EN
    aborted_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load_cfg  = 1'b1;
          core_next = '0;
          if (frame_empty) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ISSUE;
            valid_next = core_onehot('0);
            busy_next  = 1'b1;
          end
        end
      end
      ISSUE: begin
        advance = accept;
        if (accept) begin
          if (last) begin
            state_next = DONE;
            valid_next = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            core_next  = (core_idx == core_last) ? '0 : core_idx + 1'b1;
            valid_next = core_onehot(core_next);
          end
        end
`ifdef PIXEL_DISPATCH_ABORT_EN
        // An accept in the same cycle has already advanced the counter above;
        // abort only stops further issue.
        if (abort) begin
          state_next   = DONE;
          valid_next   = '0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          aborted_next = 1'b1;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        valid_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, output and latched-configuration registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      valid     <= '0;
      core_idx  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      width_m1  <= '0;
      height_m1 <= '0;
      core_last <= '0;
`ifdef PIXEL_DISPATCH_ABORT_EN
      aborted_reg <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      valid    <= valid_next;
      core_idx <= core_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
`ifdef PIXEL_DISPATCH_ABORT_EN
      aborted_reg <= aborted_next;
`endif
      if (load_cfg) begin
        width_m1  <= frame_width - 1'b1;
        height_m1 <= frame_height - 1'b1;
        core_last <= clamp_core_last(no_of_extra_cores);
      end
    end
  end

  assign job_valid_1 = valid[0];
  assign job_valid_2 = valid[1];
  assign job_valid_3 = valid[2];
  assign job_valid_4 = valid[3];
  assign busy        = busy_reg;
  assign frame_done  = done_reg;
`ifdef PIXEL_DISPATCH_ABORT_EN
  assign aborted     = aborted_reg;
`endif

endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb_pixel_dispatcher
// Directed self-checking bench for pixel_dispatcher. Each scenario task drives
// its own stimulus and compares outputs against hand-computed job sequences.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
// Optional feature macro: PIXEL_DISPATCH_ABORT_EN enables the abort scenario.
module tb_pixel_dispatcher;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       start;
  logic [9:0] frame_width;
  logic [9:0] frame_height;
  logic [2:0] no_of_extra_cores;
  logic       compute_ready_1, compute_ready_2, compute_ready_3, compute_ready_4;
  logic [9:0] job_x;
  logic [9:0] job_y;
  logic       job_valid_1, job_valid_2, job_valid_3, job_valid_4;
  logic       busy;
  logic       frame_done;
  logic [3:0] jv;
`ifdef PIXEL_DISPATCH_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  assign jv = {job_valid_4, job_valid_3, job_valid_2, job_valid_1};

  pixel_dispatcher #(
    .X_W (10),
    .Y_W (10)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .frame_width       (frame_width),
    .frame_height      (frame_height),
    .no_of_extra_cores (no_of_extra_cores),
    .compute_ready_1   (compute_ready_1),
    .compute_ready_2   (compute_ready_2),
    .compute_ready_3   (compute_ready_3),
    .compute_ready_4   (compute_ready_4),
`ifdef PIXEL_DISPATCH_ABORT_EN
    .abort             (abort),
    .aborted           (aborted),
`endif
    .job_x             (job_x),
    .job_y             (job_y),
    .job_valid_1       (job_valid_1),
    .job_valid_2       (job_valid_2),
    .job_valid_3       (job_valid_3),
    .job_valid_4       (job_valid_4),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_readies(input logic [3:0] r);
    {compute_ready_4, compute_ready_3, compute_ready_2, compute_ready_1} = r;
  endtask

  // Pulses start for one edge; afterwards the first job (if any) is visible.
  task automatic start_frame(input logic [9:0] w, input logic [9:0] h, input logic [2:0] e);
    frame_width       = w;
    frame_height      = h;
    no_of_extra_cores = e;
    start             = 1'b1;
    step();
    start             = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    step();
    step();
    checks++;
    if (job_x !== 10'd0 || job_y !== 10'd0 || jv !== 4'b0000 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got x=%0d y=%0d valid=%b busy=%b done=%b, expected all zero",
               job_x, job_y, jv, busy, frame_done);
    end
`ifdef PIXEL_DISPATCH_ABORT_EN
    checks++;
    if (aborted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_aborted: got %b, expected 0", aborted);
    end
`endif
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    logic [9:0] ex [6] = '{10'd0, 10'd1, 10'd2, 10'd0, 10'd1, 10'd2};
    logic [9:0] ey [6] = '{10'd0, 10'd0, 10'd0, 10'd1, 10'd1, 10'd1};
    logic [3:0] ev [6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    set_readies(4'b1111);
    start_frame(10'd3, 10'd2, 3'd1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (job_x !== ex[i] || job_y !== ey[i] || jv !== ev[i] || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL rr_job%0d: got x=%0d y=%0d valid=%b busy=%b, expected x=%0d y=%0d valid=%b busy=1",
                 i, job_x, job_y, jv, busy, ex[i], ey[i], ev[i]);
      end
      step();
    end
    checks++;
    if (frame_done !== 1'b1 || jv !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rr_done: got done=%b valid=%b busy=%b, expected done=1 valid=0000 busy=0",
               frame_done, jv, busy);
    end
`ifdef PIXEL_DISPATCH_ABORT_EN
    checks++;
    if (aborted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rr_aborted: got %b, expected 0 on normal completion", aborted);
    end
`endif
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rr_done_width: got done=%b, expected 0 one cycle after pulse", frame_done);
    end
  endtask

  task automatic test_stall();
    set_readies(4'b1011);
    start_frame(10'd2, 10'd2, 3'd3);
    checks++;
    if (job_x !== 10'd0 || job_y !== 10'd0 || jv !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL stall_job0: got x=%0d y=%0d valid=%b, expected x=0 y=0 valid=0001", job_x, job_y, jv);
    end
    step();
    checks++;
    if (job_x !== 10'd1 || job_y !== 10'd0 || jv !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL stall_job1: got x=%0d y=%0d valid=%b, expected x=1 y=0 valid=0010", job_x, job_y, jv);
    end
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (job_x !== 10'd0 || job_y !== 10'd1 || jv !== 4'b0100) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d: got x=%0d y=%0d valid=%b, expected x=0 y=1 valid=0100",
                 k, job_x, job_y, jv);
      end
      if (k == 4) compute_ready_3 = 1'b1;
      step();
    end
    checks++;
    if (job_x !== 10'd1 || job_y !== 10'd1 || jv !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL stall_job3: got x=%0d y=%0d valid=%b, expected x=1 y=1 valid=1000", job_x, job_y, jv);
    end
    step();
    checks++;
    if (frame_done !== 1'b1 || jv !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL stall_done: got done=%b valid=%b, expected done=1 valid=0000", frame_done, jv);
    end
    step();
  endtask

  task automatic test_clamp();
    logic [3:0] ev [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    set_readies(4'b1111);
    start_frame(10'd5, 10'd1, 3'd6);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (job_x !== 10'(i) || job_y !== 10'd0 || jv !== ev[i]) begin
        failures++;
        $display("[TB] FAIL clamp_job%0d: got x=%0d y=%0d valid=%b, expected x=%0d y=0 valid=%b",
                 i, job_x, job_y, jv, i, ev[i]);
      end
      step();
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clamp_done: got done=%b, expected 1", frame_done);
    end
    step();
  endtask

  task automatic test_empty_frame();
    int done_count = 0;
    start_frame(10'd0, 10'd4, 3'd0);
    for (int i = 0; i < 4; i++) begin
      if (frame_done === 1'b1) done_count++;
      checks++;
      if (jv !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL empty_novalid%0d: got valid=%b busy=%b, expected valid=0000 busy=0", i, jv, busy);
      end
      step();
    end
    checks++;
    if (done_count != 1) begin
      failures++;
      $display("[TB] FAIL empty_done: got %0d frame_done cycles, expected 1", done_count);
    end
  endtask

  task automatic test_ignore_midframe();
    logic [3:0] ev [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    set_readies(4'b1111);
    start_frame(10'd4, 10'd1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (job_x !== 10'(i) || job_y !== 10'd0 || jv !== ev[i]) begin
        failures++;
        $display("[TB] FAIL ignore_job%0d: got x=%0d y=%0d valid=%b, expected x=%0d y=0 valid=%b",
                 i, job_x, job_y, jv, i, ev[i]);
      end
      start = (i == 0);
      if (i == 0) begin
        frame_width       = 10'd1;
        no_of_extra_cores = 3'd3;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ignore_done: got done=%b, expected 1", frame_done);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || jv !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL ignore_start_in_done: got busy=%b valid=%b, expected busy=0 valid=0000", busy, jv);
    end
    step();
  endtask

  task automatic test_reset_midframe();
    set_readies(4'b1111);
    start_frame(10'd3, 10'd2, 3'd1);
    step();
    step();
    step();
    checks++;
    if (job_x !== 10'd0 || job_y !== 10'd1 || jv !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL rst_pixel3: got x=%0d y=%0d valid=%b, expected x=0 y=1 valid=0010", job_x, job_y, jv);
    end
    aresetn = 1'b0;
    step();
    checks++;
    if (job_x !== 10'd0 || job_y !== 10'd0 || jv !== 4'b0000 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_midframe: got x=%0d y=%0d valid=%b busy=%b done=%b, expected all zero",
               job_x, job_y, jv, busy, frame_done);
    end
    aresetn = 1'b1;
    step();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_no_done: got done=%b busy=%b, expected 0 0", frame_done, busy);
    end
    start_frame(10'd3, 10'd2, 3'd0);
    checks++;
    if (job_x !== 10'd0 || job_y !== 10'd0 || jv !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL rst_restart0: got x=%0d y=%0d valid=%b, expected x=0 y=0 valid=0001", job_x, job_y, jv);
    end
    step();
    checks++;
    if (job_x !== 10'd1 || job_y !== 10'd0 || jv !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL rst_restart1: got x=%0d y=%0d valid=%b, expected x=1 y=0 valid=0001", job_x, job_y, jv);
    end
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    step();
  endtask

`ifdef PIXEL_DISPATCH_ABORT_EN
  task automatic test_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || aborted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle: got busy=%b done=%b aborted=%b, expected 0 0 0", busy, frame_done, aborted);
    end
    set_readies(4'b1111);
    start_frame(10'd3, 10'd2, 3'd1);
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || aborted !== 1'b1 || jv !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_done: got done=%b aborted=%b valid=%b busy=%b, expected 1 1 0000 0",
               frame_done, aborted, jv, busy);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || aborted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_pulse: got done=%b aborted=%b, expected 0 0", frame_done, aborted);
    end
  endtask
`endif

  initial begin
    aresetn           = 1'b0;
    start             = 1'b0;
    frame_width       = 10'd0;
    frame_height      = 10'd0;
    no_of_extra_cores = 3'd0;
    set_readies(4'b1111);
`ifdef PIXEL_DISPATCH_ABORT_EN
    abort             = 1'b0;
`endif
    #1;
    test_reset();
    test_round_robin();
    test_stall();
    test_clamp();
    test_empty_frame();
    test_ignore_midframe();
    test_reset_midframe();
`ifdef PIXEL_DISPATCH_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
